// File: rtl/stack_controller_pkg.sv
// Shared encodings for the stack-machine controller: opcodes, ALU functions,
// FSM state encoding and the bundled control word.
package stack_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_NOT  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_POP_T    = 4'd3,
        S_POP_S    = 4'd4,
        S_WAIT_B   = 4'd5,
        S_LOAD_A   = 4'd6,
        S_TOS      = 4'd7,
        S_EXEC     = 4'd8,
        S_PUSH_RES = 4'd9,
        S_MEM_RD   = 4'd10,
        S_PUSH_MDR = 4'd11,
        S_MEM_WR   = 4'd12,
        S_JMP      = 4'd13,
        S_JZ_EVAL  = 4'd14
    } state_e;

    typedef struct packed {
        logic       pc_src;
        logic       pc_write;
        logic       pc_write_con;
        logic       z;
        logic       mem_sel;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       stack_sel;
        logic       load_a;
        logic       a_sel;
        logic       b_sel;
        logic       push;
        logic       pop;
        logic       tos;
        logic [2:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_binary_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [2:0] exec_alu_op(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_NOT:  return ALU_NOT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface stack_controller_if;

    logic [2:0] opcode;
    logic       alu_zero;
    logic       PCSrc;
    logic       pc_write;
    logic       pc_write_con;
    logic       Z;
    logic       mem_sel;
    logic       Mem_read;
    logic       Mem_write;
    logic       IR_write;
    logic       stack_sel;
    logic       load_A;
    logic       A_sel;
    logic       B_sel;
    logic       push;
    logic       pop;
    logic       tos;
    logic [2:0] ALUOP;
    logic       instr_done;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, alu_zero,
        output PCSrc, pc_write, pc_write_con, Z, mem_sel, Mem_read, Mem_write,
               IR_write, stack_sel, load_A, A_sel, B_sel, push, pop, tos,
               ALUOP, instr_done, state_dbg
    );

    modport slave (
        output opcode, alu_zero,
        input  PCSrc, pc_write, pc_write_con, Z, mem_sel, Mem_read, Mem_write,
               IR_write, stack_sel, load_A, A_sel, B_sel, push, pop, tos,
               ALUOP, instr_done, state_dbg
    );

endinterface

// File: rtl/stack_controller_decode.sv
// Moore output decode: registered state (plus opcode/alu_zero qualifiers) to
// the full datapath control word. Purely combinational.
module stack_ctrl_decode
    import stack_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [2:0] opcode,
    input  logic       alu_zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                ctrl.pc_write = 1'b1;
            end
            S_POP_T: ctrl.pop = 1'b1;
            S_POP_S: begin
                ctrl.pop    = 1'b1;
                ctrl.load_a = 1'b1;
            end
            S_LOAD_A: ctrl.load_a = 1'b1;
            S_TOS:    ctrl.tos    = 1'b1;
            S_EXEC: begin
                ctrl.a_sel  = 1'b1;
                ctrl.b_sel  = 1'b1;
                ctrl.alu_op = exec_alu_op(opcode);
            end
            S_PUSH_RES: begin
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_sel  = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            // Read stays asserted so MDR remains valid while it is pushed.
            S_PUSH_MDR: begin
                ctrl.mem_sel    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.stack_sel  = 1'b1;
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_sel    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JMP: begin
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JZ_EVAL: begin
                ctrl.a_sel        = 1'b1;
                ctrl.alu_op       = ALU_PASS;
                ctrl.pc_src       = 1'b1;
                ctrl.pc_write_con = 1'b1;
                ctrl.z            = alu_zero;
                ctrl.instr_done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_controller.sv
// Multi-cycle control FSM for the 8-bit stack-machine datapath. Holds the
// state register and next-state logic; output decode lives in stack_ctrl_decode.
module stack_controller
    import stack_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    stack_controller_if.master ctrl_if
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // IR is held stable by the datapath, so opcode steers every branch directly.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl_if.opcode)
                    OP_PUSH: state_d = S_MEM_RD;
                    OP_JMP:  state_d = S_JMP;
                    OP_JZ:   state_d = S_TOS;
                    default: state_d = S_POP_T;
                endcase
            end
            S_POP_T:  state_d = is_binary_op(ctrl_if.opcode) ? S_POP_S : S_LOAD_A;
            S_POP_S:  state_d = S_WAIT_B;
            S_WAIT_B: state_d = S_EXEC;
            S_LOAD_A: begin
                case (ctrl_if.opcode)
                    OP_NOT:  state_d = S_EXEC;
                    OP_POP:  state_d = S_MEM_WR;
                    OP_JZ:   state_d = S_JZ_EVAL;
                    default: state_d = S_INIT;
                endcase
            end
            S_TOS:      state_d = S_LOAD_A;
            S_EXEC:     state_d = S_PUSH_RES;
            S_MEM_RD:   state_d = S_PUSH_MDR;
            S_PUSH_RES,
            S_PUSH_MDR,
            S_MEM_WR,
            S_JMP,
            S_JZ_EVAL:  state_d = S_FETCH;
            default:    state_d = S_INIT;
        endcase
    end

    stack_ctrl_decode u_decode (
        .state    (state_q),
        .opcode   (ctrl_if.opcode),
        .alu_zero (ctrl_if.alu_zero),
        .ctrl     (ctrl)
    );

    assign ctrl_if.PCSrc        = ctrl.pc_src;
    assign ctrl_if.pc_write     = ctrl.pc_write;
    assign ctrl_if.pc_write_con = ctrl.pc_write_con;
    assign ctrl_if.Z            = ctrl.z;
    assign ctrl_if.mem_sel      = ctrl.mem_sel;
    assign ctrl_if.Mem_read     = ctrl.mem_read;
    assign ctrl_if.Mem_write    = ctrl.mem_write;
    assign ctrl_if.IR_write     = ctrl.ir_write;
    assign ctrl_if.stack_sel    = ctrl.stack_sel;
    assign ctrl_if.load_A       = ctrl.load_a;
    assign ctrl_if.A_sel        = ctrl.a_sel;
    assign ctrl_if.B_sel        = ctrl.b_sel;
    assign ctrl_if.push         = ctrl.push;
    assign ctrl_if.pop          = ctrl.pop;
    assign ctrl_if.tos          = ctrl.tos;
    assign ctrl_if.ALUOP        = ctrl.alu_op;
    assign ctrl_if.instr_done   = ctrl.instr_done;
    assign ctrl_if.state_dbg    = state_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: a small behavioural datapath executes the
// controller's strobes; pushed values are checked against a scoreboard queue.
module tb_stack_controller;
    import stack_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_controller_if ifc ();

    stack_controller dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (ifc)
    );

    int checks   = 0;
    int failures = 0;

    // Datapath model; loads its *_init images while rst is high.
    logic [7:0] mem_init [0:31];
    logic [7:0] stk_init [0:15];
    logic [3:0] sp_init;
    logic [4:0] pc_init;

    logic [7:0] mem [0:31];
    logic [7:0] stk [0:15];
    logic [3:0] sp;
    logic [4:0] pc;
    logic [7:0] ir, reg_a, reg_b, res, mdr, stack_out;
    logic [7:0] a_in, b_in, alu_out;
    logic [4:0] addr;

    always_comb begin
        a_in = ifc.A_sel ? reg_a : {3'b000, pc};
        b_in = ifc.B_sel ? reg_b : 8'd1;
        case (ifc.ALUOP)
            3'b000:  alu_out = a_in + b_in;
            3'b001:  alu_out = b_in - a_in;
            3'b010:  alu_out = a_in & b_in;
            3'b011:  alu_out = ~a_in;
            3'b111:  alu_out = a_in;
            default: alu_out = 8'h00;
        endcase
        addr = ifc.mem_sel ? ir[4:0] : pc;
    end

    assign ifc.opcode   = ir[7:5];
    assign ifc.alu_zero = (alu_out == 8'h00);

    always @(posedge clk) begin
        if (rst) begin
            pc        <= pc_init;
            sp        <= sp_init;
            ir        <= 8'h00;
            stack_out <= 8'h00;
            reg_a     <= 8'h00;
            reg_b     <= 8'h00;
            res       <= 8'h00;
            mdr       <= 8'h00;
            for (int i = 0; i < 32; i++) mem[i] <= mem_init[i];
            for (int i = 0; i < 16; i++) stk[i] <= stk_init[i];
        end else begin
            reg_b <= stack_out;
            if (ifc.IR_write) ir <= mem[addr];
            if (ifc.pc_write || (ifc.pc_write_con && ifc.Z))
                pc <= ifc.PCSrc ? ir[4:0] : alu_out[4:0];
            if (ifc.Mem_read)  mdr <= mem[addr];
            if (ifc.Mem_write) mem[addr] <= reg_a;
            if (ifc.load_A)    reg_a <= stack_out;
            if (ifc.pop) begin
                stack_out <= stk[sp - 4'd1];
                sp        <= sp - 4'd1;
            end
            if (ifc.tos) stack_out <= stk[sp - 4'd1];
            if (ifc.push) begin
                stk[sp] <= ifc.stack_sel ? mdr : res;
                sp      <= sp + 4'd1;
            end
            if (ifc.A_sel && ifc.B_sel) res <= alu_out;
        end
    end

    logic [18:0] outs;
    assign outs = {ifc.PCSrc, ifc.pc_write, ifc.pc_write_con, ifc.Z, ifc.mem_sel,
                   ifc.Mem_read, ifc.Mem_write, ifc.IR_write, ifc.stack_sel,
                   ifc.load_A, ifc.A_sel, ifc.B_sel, ifc.push, ifc.pop, ifc.tos,
                   ifc.ALUOP, ifc.instr_done};

    // Scoreboard of values the datapath should receive on push.
    logic [7:0] exp_push_q [$];
    logic [7:0] mon_data, mon_exp;

    always @(negedge clk) begin
        if (ifc.push) begin
            checks++;
            mon_data = ifc.stack_sel ? mdr : res;
            if (exp_push_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_push got=%02h required=none", mon_data);
            end else begin
                mon_exp = exp_push_q.pop_front();
                if (mon_data !== mon_exp) begin
                    failures++;
                    $display("FAIL push_value got=%02h required=%02h", mon_data, mon_exp);
                end
            end
        end
        checks++;
        if ((int'(ifc.push) + int'(ifc.pop) + int'(ifc.tos)) > 1 ||
            (ifc.Mem_read && ifc.Mem_write)) begin
            failures++;
            $display("FAIL exclusive_strobes got=%b required=at_most_one", outs);
        end
    end

    int         r_cycles;
    logic [3:0] r_first;
    logic [2:0] r_exec_op;
    int         r_writes;
    logic       r_rd_sel, r_z, r_pcwc;

    // Runs one instruction from its FETCH cycle to instr_done (bounded at 20).
    task automatic run_instr();
        r_cycles = 0; r_writes = 0; r_exec_op = 3'b110;
        r_rd_sel = 1'b0; r_z = 1'b0; r_pcwc = 1'b0; r_first = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r_cycles++;
            if (i == 0) r_first = ifc.state_dbg;
            if (ifc.state_dbg == S_EXEC) r_exec_op = ifc.ALUOP;
            if (ifc.state_dbg == S_MEM_RD) r_rd_sel = ifc.mem_sel & ifc.Mem_read;
            if (ifc.Mem_write) r_writes++;
            if (ifc.instr_done) begin
                r_z    = ifc.Z;
                r_pcwc = ifc.pc_write_con;
                break;
            end
        end
    endtask

    task automatic start_prog(input logic [4:0] pc0);
        rst     = 1'b1;
        pc_init = pc0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] fetch_got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h required=0", outs);
        end
        checks++;
        if (ifc.state_dbg !== S_INIT) begin
            failures++; $display("FAIL reset_state got=%0d required=%0d", ifc.state_dbg, S_INIT);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.state_dbg !== S_FETCH) begin
            failures++; $display("FAIL first_fetch_state got=%0d required=%0d", ifc.state_dbg, S_FETCH);
        end
        fetch_got = {ifc.mem_sel, ifc.Mem_read, ifc.IR_write, ifc.pc_write,
                     ifc.PCSrc, ifc.A_sel, ifc.B_sel, ifc.ALUOP};
        checks++;
        if (fetch_got !== 10'b0111000000) begin
            failures++; $display("FAIL fetch_strobes got=%b required=0111000000", fetch_got);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.state_dbg !== S_INIT || outs !== '0) begin
            failures++; $display("FAIL async_reset got=%0d/%h required=%0d/0", ifc.state_dbg, outs, S_INIT);
        end
    endtask

    task automatic test_back_to_back_alu();
        int         exp_cyc  [4] = '{7, 7, 7, 6};
        logic [2:0] exp_op   [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [7:0] exp_push [4] = '{8'h08, 8'hFE, 8'h14, 8'hEB};
        stk_init[0] = 8'd20; stk_init[1] = 8'd6; stk_init[2] = 8'd5; stk_init[3] = 8'd3;
        sp_init = 4'd4;
        mem_init[0] = 8'h00; mem_init[1] = 8'h20; mem_init[2] = 8'h40; mem_init[3] = 8'h60;
        start_prog(5'd0);
        for (int k = 0; k < 4; k++) begin
            exp_push_q.push_back(exp_push[k]);
            run_instr();
            checks++;
            if (r_cycles != exp_cyc[k] || r_first !== S_FETCH) begin
                failures++;
                $display("FAIL alu_cycles[%0d] got=%0d first=%0d required=%0d first=%0d",
                         k, r_cycles, r_first, exp_cyc[k], S_FETCH);
            end
            checks++;
            if (r_exec_op !== exp_op[k]) begin
                failures++; $display("FAIL alu_op[%0d] got=%b required=%b", k, r_exec_op, exp_op[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (sp !== 4'd1 || stk[0] !== 8'hEB) begin
            failures++; $display("FAIL alu_stack got=sp%0d/%02h required=sp1/eb", sp, stk[0]);
        end
    endtask

    task automatic test_push_pop();
        mem_init[0] = 8'h9B; mem_init[1] = 8'hBE; mem_init[27] = 8'h5A; mem_init[30] = 8'h00;
        sp_init = 4'd0;
        start_prog(5'd0);
        exp_push_q.push_back(8'h5A);
        run_instr();
        checks++;
        if (r_cycles != 4 || r_rd_sel !== 1'b1) begin
            failures++; $display("FAIL push_instr got=%0d/%b required=4/1", r_cycles, r_rd_sel);
        end
        run_instr();
        checks++;
        if (r_cycles != 5 || r_writes != 1) begin
            failures++; $display("FAIL pop_instr got=%0d/%0d required=5/1", r_cycles, r_writes);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (mem[30] !== 8'h5A || sp !== 4'd0) begin
            failures++; $display("FAIL pop_mem got=%02h/sp%0d required=5a/sp0", mem[30], sp);
        end
    endtask

    task automatic test_jz();
        logic [7:0] tops   [2] = '{8'h00, 8'h04};
        logic [4:0] exp_pc [2] = '{5'd17, 5'd6};
        logic       exp_z  [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            stk_init[0] = tops[k]; sp_init = 4'd1; mem_init[5] = 8'hF1;
            start_prog(5'd5);
            run_instr();
            checks++;
            if (r_cycles != 5 || r_z !== exp_z[k] || r_pcwc !== 1'b1) begin
                failures++;
                $display("FAIL jz_eval[%0d] got=%0d/z%b/c%b required=5/z%b/c1", k, r_cycles, r_z, r_pcwc, exp_z[k]);
            end
            @(posedge clk); #1;
            rst = 1'b1;
            checks++;
            if (pc !== exp_pc[k] || sp !== 4'd1) begin
                failures++; $display("FAIL jz_pc[%0d] got=%0d/sp%0d required=%0d/sp1", k, pc, sp, exp_pc[k]);
            end
        end
    endtask

    task automatic test_jmp_wrap();
        mem_init[4] = 8'hDF; mem_init[31] = 8'hDF;
        start_prog(5'd4);
        run_instr();
        checks++;
        if (r_cycles != 3) begin
            failures++; $display("FAIL jmp_cycles got=%0d required=3", r_cycles);
        end
        @(posedge clk); #1;
        checks++;
        if (pc !== 5'd31 || ifc.state_dbg !== S_FETCH) begin
            failures++; $display("FAIL jmp_target got=%0d/%0d required=31/%0d", pc, ifc.state_dbg, S_FETCH);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (pc !== 5'd0 || ir !== 8'hDF) begin
            failures++; $display("FAIL pc_wrap got=%0d/%02h required=0/df", pc, ir);
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        stk_init[0] = 8'd5; stk_init[1] = 8'd3; sp_init = 4'd2; mem_init[0] = 8'h00;
        start_prog(5'd0);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ifc.state_dbg == S_WAIT_B) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL reach_wait_b got=timeout required=%0d", S_WAIT_B);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.state_dbg !== S_INIT || outs !== '0) begin
            failures++; $display("FAIL mid_reset got=%0d/%h required=%0d/0", ifc.state_dbg, outs, S_INIT);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ifc.push !== 1'b0) begin
                failures++; $display("FAIL push_after_reset got=%b required=0", ifc.push);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem_init[i] = 8'h00;
        for (int i = 0; i < 16; i++) stk_init[i] = 8'h00;
        sp_init = 4'd0;
        pc_init = 5'd0;
        test_reset();
        test_back_to_back_alu();
        test_push_pop();
        test_jz();
        test_jmp_wrap();
        test_reset_mid();
        checks++;
        if (exp_push_q.size() != 0) begin
            failures++; $display("FAIL pending_pushes got=%0d required=0", exp_push_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
